// File: rtl/integer_offset_remover.sv
// rtl/integer_offset_remover.sv - removes a fixed integer offset from a valid/ready stream
// Two-entry skid buffer with registered in_ready, plus saturating delivery counters.
module integer_offset_remover #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] OFFSET = WIDTH'(10)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_underflow,
   input  logic             clear_counts,
   output logic [15:0]      count_words,
   output logic [15:0]      count_underflow
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

   occ_t             state_q, state_d;
   logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
   logic             head_uf_q, head_uf_d, skid_uf_q, skid_uf_d;
   logic             in_ready_q;
   logic [15:0]      cnt_words_q, cnt_uf_q;

   logic             accept, consume;
   logic [WIDTH-1:0] new_data;
   logic             new_uf;

   assign new_data = in_data - OFFSET;
   assign new_uf   = (in_data < OFFSET);
   assign accept   = in_valid && in_ready_q;
   assign consume  = out_valid && out_ready;

   assign in_ready        = in_ready_q;
   assign out_valid       = (state_q != EMPTY);
   assign out_data        = head_data_q;
   assign out_underflow   = head_uf_q;
   assign count_words     = cnt_words_q;
   assign count_underflow = cnt_uf_q;

   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_uf_d   = head_uf_q;
      skid_data_d = skid_data_q;
      skid_uf_d   = skid_uf_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = ONE;
               head_data_d = new_data;
               head_uf_d   = new_uf;
            end
         end
         ONE: begin
            if (accept && consume) begin
               head_data_d = new_data;
               head_uf_d   = new_uf;
            end else if (accept) begin
               state_d     = FULL;
               skid_data_d = new_data;
               skid_uf_d   = new_uf;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only a consume can happen
            if (consume) begin
               state_d     = ONE;
               head_data_d = skid_data_q;
               head_uf_d   = skid_uf_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_uf_q   <= 1'b0;
         skid_data_q <= '0;
         skid_uf_q   <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_uf_q   <= head_uf_d;
         skid_data_q <= skid_data_d;
         skid_uf_q   <= skid_uf_d;
         in_ready_q  <= (state_d != FULL);
      end
   end

   // clear_counts wins over a same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_words_q <= '0;
         cnt_uf_q    <= '0;
      end else if (clear_counts) begin
         cnt_words_q <= '0;
         cnt_uf_q    <= '0;
      end else if (consume) begin
         if (cnt_words_q != 16'hFFFF) cnt_words_q <= cnt_words_q + 16'd1;
         if (head_uf_q && cnt_uf_q != 16'hFFFF) cnt_uf_q <= cnt_uf_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_integer_offset_remover.sv
// tb/tb_integer_offset_remover.sv - self-checking bench for integer_offset_remover
module tb_integer_offset_remover;

   localparam int          W   = 32;
   localparam logic [31:0] OFF = 32'd10;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, out_valid, out_ready, out_underflow, clear_counts;
   logic [W-1:0]  in_data, out_data;
   logic [15:0]   count_words, count_underflow;

   logic          in_valid0, in_ready0, out_valid0, out_ready0, out_underflow0, clear_counts0;
   logic [W-1:0]  in_data0, out_data0;
   logic [15:0]   count_words0, count_underflow0;

   always #5 clk = ~clk;

   integer_offset_remover #(.WIDTH(W), .OFFSET(OFF)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_underflow(out_underflow), .clear_counts(clear_counts),
      .count_words(count_words), .count_underflow(count_underflow)
   );

   integer_offset_remover #(.WIDTH(W), .OFFSET(32'd0)) dut0 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .out_underflow(out_underflow0), .clear_counts(clear_counts0),
      .count_words(count_words0), .count_underflow(count_underflow0)
   );

   int           checks = 0;
   int           errors = 0;
   logic [W:0]   q[$];
   logic [15:0]  m_cw, m_cu;
   int           delivered;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the reference queue, then advance the model.
   task automatic cycle(input bit toggle_check);
      logic       acc, cons, popped_uf;
      logic [W:0] popped;
      @(negedge clk);
      chk("in_ready", in_ready, 64'(q.size() < 2));
      chk("out_valid", out_valid, 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("out_data", out_data, 64'(q[0][W-1:0]));
         chk("out_underflow", out_underflow, 64'(q[0][W]));
      end
      chk("count_words", count_words, 64'(m_cw));
      chk("count_underflow", count_underflow, 64'(m_cu));
      if (toggle_check) begin
         out_ready = ~out_ready;
         #1;
         chk("in_ready_vs_out_ready", in_ready, 64'(q.size() < 2));
         out_ready = ~out_ready;
         #1;
      end
      acc  = in_valid && (q.size() < 2);
      cons = out_ready && (q.size() > 0);
      popped_uf = 1'b0;
      @(posedge clk);
      #1;
      if (cons) begin
         popped = q.pop_front();
         popped_uf = popped[W];
         delivered++;
      end
      if (acc) q.push_back({in_data < OFF, in_data - OFF});
      if (clear_counts) begin
         m_cw = 0;
         m_cu = 0;
      end else if (cons) begin
         if (m_cw != 16'hFFFF) m_cw = m_cw + 1;
         if (popped_uf && m_cu != 16'hFFFF) m_cu = m_cu + 1;
      end
   endtask

   logic [31:0] vals [4];
   logic [31:0] exps [4];
   logic        expf [4];

   initial begin
      int budget;
      vals = '{32'd1, 32'd10, 32'd25, 32'hFFFFFFFF};
      exps = '{32'hFFFFFFF7, 32'd0, 32'd15, 32'hFFFFFFF5};
      expf = '{1'b1, 1'b0, 1'b0, 1'b0};
      reset = 1'b1;
      in_valid = 0; in_data = 0; out_ready = 0; clear_counts = 0;
      in_valid0 = 0; in_data0 = 0; out_ready0 = 0; clear_counts0 = 0;
      m_cw = 0; m_cu = 0; delivered = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_underflow", out_underflow, 0);
      chk("rst_count_words", count_words, 0);
      chk("rst_count_underflow", count_underflow, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // zero-offset build passes words through unchanged
      in_valid0 = 1; out_ready0 = 1; in_data0 = 32'd0;
      @(posedge clk); #1;
      chk("off0_valid_a", out_valid0, 1);
      chk("off0_data_a", out_data0, 0);
      chk("off0_uf_a", out_underflow0, 0);
      in_data0 = 32'hFFFFFFFF;
      @(posedge clk); #1;
      chk("off0_data_b", out_data0, 32'hFFFFFFFF);
      chk("off0_uf_b", out_underflow0, 0);
      in_valid0 = 0;

      // streaming at full rate
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = vals[i];
         cycle(0);
         chk("stream_valid", out_valid, 1);
         chk("stream_data", out_data, exps[i]);
         chk("stream_uf", out_underflow, expf[i]);
      end
      in_valid = 0;
      cycle(0);
      chk("stream_count_words", count_words, 4);
      chk("stream_count_uf", count_underflow, 1);

      // backpressure: only two words accepted
      out_ready = 0; in_valid = 1; in_data = 32'd5;
      cycle(0);
      in_data = 32'd20;
      cycle(0);
      in_data = 32'd99;
      cycle(0);
      cycle(0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_head", out_data, 32'hFFFFFFFB);
      chk("bp_head_uf", out_underflow, 1);
      in_valid = 0; out_ready = 1;
      cycle(0);
      chk("bp_second", out_data, 32'd10);
      chk("bp_in_ready_back", in_ready, 1);
      cycle(0);
      cycle(0);

      // clear wins over a same-cycle handshake
      in_valid = 1; in_data = 32'd3;
      cycle(0);
      in_valid = 0; clear_counts = 1;
      cycle(0);
      clear_counts = 0;
      chk("clear_words", count_words, 0);
      chk("clear_uf", count_underflow, 0);

      // reset while FULL discards buffered words
      out_ready = 0; in_valid = 1; in_data = 32'd7;
      cycle(0);
      cycle(0);
      in_valid = 0;
      reset = 1;
      #2;
      chk("rstfull_out_valid", out_valid, 0);
      chk("rstfull_in_ready", in_ready, 1);
      chk("rstfull_count_words", count_words, 0);
      chk("rstfull_count_uf", count_underflow, 0);
      @(posedge clk); #1;
      reset = 0;
      q.delete(); m_cw = 0; m_cu = 0;
      out_ready = 1;
      cycle(0);
      cycle(0);

      // random traffic against the reference queue
      delivered = 0;
      budget = 0;
      while (delivered < 10000 && budget < 40000) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = ($urandom % 4 == 0) ? ($urandom % 20) : $urandom;
         out_ready = ($urandom % 4) != 0;
         cycle(1);
         budget++;
      end
      chk("random_budget", 64'(delivered >= 10000), 1);

      // saturation of the word counter
      in_valid = 1; out_ready = 1;
      budget = 0;
      while (delivered < 65540 && budget < 70000) begin
         in_data = ($urandom % 3 == 0) ? ($urandom % 10) : $urandom;
         cycle(0);
         budget++;
      end
      chk("sat_budget", 64'(delivered >= 65540), 1);
      in_valid = 0;
      cycle(0);
      cycle(0);
      chk("sat_count_words", count_words, 16'hFFFF);

      in_valid = 1; in_data = 32'd2;
      cycle(0);
      in_valid = 0; clear_counts = 1;
      cycle(0);
      clear_counts = 0;
      chk("sat_clear_words", count_words, 0);
      chk("sat_clear_uf", count_underflow, 0);
      cycle(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
